// File: rtl/rvfi_trace_serializer.sv
// rvfi_trace_serializer
//
// Merges up to NrCommitPorts retired-instruction records per cycle, as
// presented by the RVFI packer, into one ordered stream of one record per
// cycle toward a trace sink. Records pass through a circular FIFO. Each
// record is tagged with a 64-bit retirement order number. When a cycle's
// records do not all fit, that cycle's records are dropped and counted
// instead of stalling the core.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             synchronous FIFO clear; that cycle's inputs are discarded
//   in_*_i              per-lane RVFI record fields, lane l at slice l
//   out_valid_o/ready_i valid/ready handshake toward the sink
//   out_order_o, out_*  head record fields (all zero while empty)
//   overflow_o          sticky flag, set once any record has been dropped
//   drop_cnt_o          saturating count of dropped records
//   level_o             current FIFO occupancy
module rvfi_trace_serializer #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned VLEN          = 64,
  parameter int unsigned Depth         = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [NrCommitPorts-1:0]          in_valid_i,
  input  logic [NrCommitPorts*VLEN-1:0]     in_pc_i,
  input  logic [NrCommitPorts*32-1:0]       in_insn_i,
  input  logic [NrCommitPorts-1:0]          in_trap_i,
  input  logic [NrCommitPorts*XLEN-1:0]     in_cause_i,
  input  logic [NrCommitPorts*2-1:0]        in_mode_i,
  input  logic [NrCommitPorts*5-1:0]        in_rd_addr_i,
  input  logic [NrCommitPorts*XLEN-1:0]     in_rd_wdata_i,
  input  logic [NrCommitPorts*VLEN-1:0]     in_mem_addr_i,
  input  logic [NrCommitPorts*XLEN/8-1:0]   in_mem_wmask_i,
  input  logic [NrCommitPorts*XLEN/8-1:0]   in_mem_rmask_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [63:0]                       out_order_o,
  output logic [VLEN-1:0]                   out_pc_o,
  output logic [31:0]                       out_insn_o,
  output logic                              out_trap_o,
  output logic [XLEN-1:0]                   out_cause_o,
  output logic [1:0]                        out_mode_o,
  output logic [4:0]                        out_rd_addr_o,
  output logic [XLEN-1:0]                   out_rd_wdata_o,
  output logic [VLEN-1:0]                   out_mem_addr_o,
  output logic [XLEN/8-1:0]                 out_mem_wmask_o,
  output logic [XLEN/8-1:0]                 out_mem_rmask_o,
  output logic                              overflow_o,
  output logic [31:0]                       drop_cnt_o,
  output logic [$clog2(Depth):0]            level_o
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned MW = XLEN / 8;

  typedef struct packed {
    logic [63:0]     order;
    logic [VLEN-1:0] pc;
    logic [31:0]     insn;
    logic            trap;
    logic [XLEN-1:0] cause;
    logic [1:0]      mode;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [VLEN-1:0] mem_addr;
    logic [MW-1:0]   mem_wmask;
    logic [MW-1:0]   mem_rmask;
  } rec_t;

  // Control state
  logic [LW-1:0] r_level;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [63:0]   r_order;
  logic          r_overflow;
  logic [31:0]   r_drop_cnt;

  // Record storage (data only, never reset)
  rec_t          r_mem [Depth];

  logic [LW-1:0] w_n;
  logic [PW-1:0] w_slot [NrCommitPorts];
  rec_t          w_rec  [NrCommitPorts];
  logic [LW-1:0] w_free;
  logic          w_admit;
  logic          w_drop;
  logic          w_pop;
  logic [32:0]   w_drop_sum;
  rec_t          w_head;

  // Lane compaction: a valid lane lands in the slot that follows the write
  // pointer by the number of valid lanes below it. Invalid lanes consume no
  // slot and no order number. w_n is the running count and ends as popcount.
  always_comb begin
    w_n = '0;
    for (int l = 0; l < NrCommitPorts; l++) begin
      w_slot[l]          = r_wptr + w_n[PW-1:0];
      w_rec[l].order     = r_order + 64'(w_n);
      w_rec[l].pc        = in_pc_i[l*VLEN +: VLEN];
      w_rec[l].insn      = in_insn_i[l*32 +: 32];
      w_rec[l].trap      = in_trap_i[l];
      w_rec[l].cause     = in_cause_i[l*XLEN +: XLEN];
      w_rec[l].mode      = in_mode_i[l*2 +: 2];
      w_rec[l].rd_addr   = in_rd_addr_i[l*5 +: 5];
      w_rec[l].rd_wdata  = in_rd_wdata_i[l*XLEN +: XLEN];
      w_rec[l].mem_addr  = in_mem_addr_i[l*VLEN +: VLEN];
      w_rec[l].mem_wmask = in_mem_wmask_i[l*MW +: MW];
      w_rec[l].mem_rmask = in_mem_rmask_i[l*MW +: MW];
      if (in_valid_i[l]) w_n = w_n + LW'(1);
    end
  end

  // Admission is decided on the occupancy at the start of the cycle. A pop in
  // the same cycle does not make room for this cycle's records.
  assign w_free     = LW'(Depth) - r_level;
  assign w_admit    = !flush_i && (w_n != '0) && (w_n <= w_free);
  assign w_drop     = !flush_i && (w_n > w_free);
  assign w_pop      = (r_level != '0) && out_ready_i;
  assign w_drop_sum = {1'b0, r_drop_cnt} + 33'(w_n);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_level    <= '0;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_order    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (flush_i) begin
      r_level <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
    end else begin
      if (w_admit) r_wptr <= r_wptr + w_n[PW-1:0];
      if (w_pop)   r_rptr <= r_rptr + PW'(1);
      r_level <= r_level + (w_admit ? w_n : '0) - (w_pop ? LW'(1) : '0);
      // The order counter advances for dropped records too, so the sink can
      // spot the loss as a gap in order numbers.
      r_order <= r_order + 64'(w_n);
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_admit) begin
      for (int l = 0; l < NrCommitPorts; l++) begin
        if (in_valid_i[l]) r_mem[w_slot[l]] <= w_rec[l];
      end
    end
  end

  // The head is read straight from storage, so it holds while stalled. It is
  // forced to zero when empty so stale entries never appear on the output.
  assign w_head = (r_level != '0) ? r_mem[r_rptr] : '0;

  assign out_valid_o     = (r_level != '0);
  assign out_order_o     = w_head.order;
  assign out_pc_o        = w_head.pc;
  assign out_insn_o      = w_head.insn;
  assign out_trap_o      = w_head.trap;
  assign out_cause_o     = w_head.cause;
  assign out_mode_o      = w_head.mode;
  assign out_rd_addr_o   = w_head.rd_addr;
  assign out_rd_wdata_o  = w_head.rd_wdata;
  assign out_mem_addr_o  = w_head.mem_addr;
  assign out_mem_wmask_o = w_head.mem_wmask;
  assign out_mem_rmask_o = w_head.mem_rmask;
  assign overflow_o      = r_overflow;
  assign drop_cnt_o      = r_drop_cnt;
  assign level_o         = r_level;

endmodule

// File: tb/tb_rvfi_trace_serializer.sv
module tb_rvfi_trace_serializer;

  localparam int NP = 2;
  localparam int D  = 8;

  typedef struct packed {
    logic [63:0] order;
    logic [63:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [63:0] cause;
    logic [1:0]  mode;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic [63:0] maddr;
    logic [7:0]  wm;
    logic [7:0]  rm;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [NP-1:0]   in_valid;
  logic [NP*64-1:0] in_pc, in_cause, in_wdata, in_maddr;
  logic [NP*32-1:0] in_insn;
  logic [NP-1:0]   in_trap;
  logic [NP*2-1:0] in_mode;
  logic [NP*5-1:0] in_rd;
  logic [NP*8-1:0] in_wm, in_rm;
  logic            out_valid, out_ready;
  logic [63:0]     out_order, out_pc, out_cause, out_wdata, out_maddr;
  logic [31:0]     out_insn;
  logic            out_trap;
  logic [1:0]      out_mode;
  logic [4:0]      out_rd;
  logic [7:0]      out_wm, out_rm;
  logic            overflow;
  logic [31:0]     drop_cnt;
  logic [3:0]      level;

  rec_t lane [NP];
  rec_t dut_rec;
  rec_t mq [$];
  logic [63:0] m_order;
  logic [31:0] m_drop;
  logic        m_ovf;
  bit          chk_en = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rvfi_trace_serializer #(.NrCommitPorts(NP), .XLEN(64), .VLEN(64), .Depth(D)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_pc_i(in_pc), .in_insn_i(in_insn), .in_trap_i(in_trap),
    .in_cause_i(in_cause), .in_mode_i(in_mode), .in_rd_addr_i(in_rd),
    .in_rd_wdata_i(in_wdata), .in_mem_addr_i(in_maddr),
    .in_mem_wmask_i(in_wm), .in_mem_rmask_i(in_rm),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_order_o(out_order),
    .out_pc_o(out_pc), .out_insn_o(out_insn), .out_trap_o(out_trap),
    .out_cause_o(out_cause), .out_mode_o(out_mode), .out_rd_addr_o(out_rd),
    .out_rd_wdata_o(out_wdata), .out_mem_addr_o(out_maddr),
    .out_mem_wmask_o(out_wm), .out_mem_rmask_o(out_rm),
    .overflow_o(overflow), .drop_cnt_o(drop_cnt), .level_o(level)
  );

  always_comb begin
    in_pc = '0; in_insn = '0; in_trap = '0; in_cause = '0; in_mode = '0;
    in_rd = '0; in_wdata = '0; in_maddr = '0; in_wm = '0; in_rm = '0;
    for (int l = 0; l < NP; l++) begin
      in_pc[l*64 +: 64]    = lane[l].pc;
      in_insn[l*32 +: 32]  = lane[l].insn;
      in_trap[l]           = lane[l].trap;
      in_cause[l*64 +: 64] = lane[l].cause;
      in_mode[l*2 +: 2]    = lane[l].mode;
      in_rd[l*5 +: 5]      = lane[l].rd;
      in_wdata[l*64 +: 64] = lane[l].wdata;
      in_maddr[l*64 +: 64] = lane[l].maddr;
      in_wm[l*8 +: 8]      = lane[l].wm;
      in_rm[l*8 +: 8]      = lane[l].rm;
    end
  end

  assign dut_rec = {out_order, out_pc, out_insn, out_trap, out_cause, out_mode,
                    out_rd, out_wdata, out_maddr, out_wm, out_rm};

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of records, updated from the rules at each edge.
  always @(posedge clk) begin : model
    int n, free, k;
    logic [32:0] s;
    rec_t r;
    if (rst) begin
      mq.delete(); m_order = 0; m_drop = 0; m_ovf = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      n = $countones(in_valid);
      free = D - mq.size();
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (n <= free) begin
        k = 0;
        for (int l = 0; l < NP; l++) begin
          if (in_valid[l]) begin
            r = lane[l];
            r.order = m_order + 64'(k);
            mq.push_back(r);
            k++;
          end
        end
      end else begin
        s = {1'b0, m_drop} + 33'(n);
        m_drop = s[32] ? 32'hFFFF_FFFF : s[31:0];
        m_ovf = 1'b1;
      end
      m_order = m_order + 64'(n);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 512'(level), 512'(mq.size()));
      chk("valid", 512'(out_valid), 512'(mq.size() != 0));
      chk("drop_cnt", 512'(drop_cnt), 512'(m_drop));
      chk("overflow", 512'(overflow), 512'(m_ovf));
      if (mq.size() != 0) chk("head", 512'(dut_rec), 512'(mq[0]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rand_lanes();
    for (int l = 0; l < NP; l++) begin
      lane[l].order = '0;
      lane[l].pc    = {$urandom, $urandom};
      lane[l].insn  = $urandom;
      lane[l].trap  = 1'($urandom);
      lane[l].cause = {$urandom, $urandom};
      lane[l].mode  = 2'($urandom);
      lane[l].rd    = 5'($urandom);
      lane[l].wdata = {$urandom, $urandom};
      lane[l].maddr = {$urandom, $urandom};
      lane[l].wm    = 8'($urandom);
      lane[l].rm    = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; in_valid = '0;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = '0; out_ready = 1;
    rand_lanes();
    tick();
    chk_en = 1;
    tick();
    chk("rst_head_zero", 512'(dut_rec), 512'(0));
    chk("rst_level", 512'(level), 512'(0));
    rst = 0;

    // Two lanes, consecutive output
    do_reset();
    out_ready = 1; rand_lanes();
    lane[0].pc = 64'h1000; lane[1].pc = 64'h1004; in_valid = 2'b11;
    tick();
    chk("s1_level", 512'(level), 512'(2));
    chk("s1_pc0", 512'(out_pc), 512'(64'h1000));
    chk("s1_ord0", 512'(out_order), 512'(0));
    in_valid = 2'b00;
    tick();
    chk("s1_pc1", 512'(out_pc), 512'(64'h1004));
    chk("s1_ord1", 512'(out_order), 512'(1));
    tick();

    // Only lane 1 valid
    do_reset();
    rand_lanes(); lane[1].pc = 64'h2000; in_valid = 2'b10; out_ready = 0;
    tick();
    chk("s2_level", 512'(level), 512'(1));
    chk("s2_pc", 512'(out_pc), 512'(64'h2000));
    chk("s2_ord", 512'(out_order), 512'(0));
    in_valid = 0; out_ready = 1;
    tick(); tick();

    // Overflow with ready low
    do_reset();
    out_ready = 0;
    repeat (4) begin rand_lanes(); in_valid = 2'b11; tick(); end
    chk("s3_full", 512'(level), 512'(8));
    rand_lanes(); tick();
    chk("s3_drop", 512'(drop_cnt), 512'(2));
    chk("s3_ovf", 512'(overflow), 512'(1));
    chk("s3_level", 512'(level), 512'(8));
    in_valid = 0; out_ready = 1;
    repeat (8) tick();
    chk("s3_empty", 512'(level), 512'(0));
    out_ready = 0; rand_lanes(); in_valid = 2'b01;
    tick();
    chk("s3_gap_ord", 512'(out_order), 512'(10));

    // level 7, two lanes, simultaneous pop -> both dropped
    do_reset();
    out_ready = 0;
    repeat (3) begin rand_lanes(); in_valid = 2'b11; tick(); end
    rand_lanes(); in_valid = 2'b01; tick();
    chk("s4_l7", 512'(level), 512'(7));
    rand_lanes(); in_valid = 2'b11; out_ready = 1;
    tick();
    chk("s4_level", 512'(level), 512'(6));
    chk("s4_drop", 512'(drop_cnt), 512'(2));
    in_valid = 0;
    repeat (7) tick();

    // Back-pressure: ready toggles, 20 single pushes
    do_reset();
    for (int i = 0; i < 40; i++) begin
      out_ready = i[0];
      rand_lanes();
      in_valid = (i % 2 == 0) ? 2'b01 : 2'b00;
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (12) tick();
    chk("s5_drained", 512'(level), 512'(0));
    chk("s5_nodrop", 512'(drop_cnt), 512'(0));

    // Flush with level 5, then reset mid-stream
    do_reset();
    out_ready = 0;
    rand_lanes(); in_valid = 2'b11; tick();
    rand_lanes(); tick();
    rand_lanes(); in_valid = 2'b01; tick();
    chk("s6_l5", 512'(level), 512'(5));
    rand_lanes(); in_valid = 2'b11; flush = 1;
    tick();
    flush = 0;
    chk("s6_flush_level", 512'(level), 512'(0));
    chk("s6_flush_drop", 512'(drop_cnt), 512'(0));
    rand_lanes(); in_valid = 2'b01;
    tick();
    chk("s6_ord_cont", 512'(out_order), 512'(5));
    rand_lanes(); in_valid = 2'b11; tick();
    rst = 1; tick(); rst = 0; in_valid = 0;
    chk("s6_rst_head", 512'(dut_rec), 512'(0));
    chk("s6_rst_valid", 512'(out_valid), 512'(0));
    chk("s6_rst_level", 512'(level), 512'(0));

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rand_lanes();
      in_valid  = NP'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (10) tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rvfi_trace_serializer.md
Name: rvfi_trace_serializer

Overview:
- Sits directly downstream of the RVFI packer and consumes its per-commit-port retired-instruction records (valid, pc, insn, trap, cause, mode, rd, memory fields).
- Merges the up-to-NrCommitPorts records retired each cycle into one ordered stream of one record per cycle, through a circular FIFO.
- The output uses a valid/ready handshake toward a trace sink (DPI logger, trace port, or on-chip trace RAM).
- Each record is tagged with a 64-bit retirement order number; overflow is counted rather than stalling the core.

Parameters:
NrCommitPorts, 2, number of RVFI lanes presented per cycle (1..4)
XLEN, 64, register/data width
VLEN, 64, virtual address width
Depth, 8, FIFO entries; power of two, >= NrCommitPorts

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  synchronous FIFO clear (sink reconfiguration)
in_valid_i  in  NrCommitPorts  per-lane record valid
in_pc_i  in  NrCommitPorts*VLEN  per-lane pc_rdata
in_insn_i  in  NrCommitPorts*32  per-lane instruction word
in_trap_i  in  NrCommitPorts  per-lane trap flag
in_cause_i  in  NrCommitPorts*XLEN  per-lane trap cause
in_mode_i  in  NrCommitPorts*2  per-lane privilege mode
in_rd_addr_i  in  NrCommitPorts*5  per-lane rd address
in_rd_wdata_i  in  NrCommitPorts*XLEN  per-lane rd write data
in_mem_addr_i  in  NrCommitPorts*VLEN  per-lane memory address
in_mem_wmask_i  in  NrCommitPorts*(XLEN/8)  per-lane store byte mask
in_mem_rmask_i  in  NrCommitPorts*(XLEN/8)  per-lane load byte mask
out_valid_o  out  1  record available
out_ready_i  in  1  sink accepts record
out_order_o  out  64  retirement order number of the record
out_pc_o, out_insn_o, out_trap_o, out_cause_o, out_mode_o, out_rd_addr_o, out_rd_wdata_o, out_mem_addr_o, out_mem_wmask_o, out_mem_rmask_o  out  same widths as one lane  head record fields
overflow_o  out  1  sticky: at least one record dropped
drop_cnt_o  out  32  count of dropped records, saturating
level_o  out  $clog2(Depth)+1  current FIFO occupancy

Behaviour:
- Reset (rst_i=1 at posedge): FIFO empty, read/write pointers 0, order counter 0. Outputs: out_valid_o=0, overflow_o=0, drop_cnt_o=0, level_o=0, all out_* data fields 0.
- Lane compaction: valid lanes are written in ascending lane index to consecutive slots from the write pointer. Gaps are allowed (e.g. only lane 1 valid), and no empty entry is written for an invalid lane.
- n = popcount(in_valid_i). free = Depth - level at the start of the cycle; a same-cycle pop is not credited.
- Admission is all-or-nothing per cycle:
  - If n <= free, all n records are written, each tagged order_q+k (k = compacted index).
  - If n > free, all n records are dropped, drop_cnt_o += n (saturating at 2^32-1), and overflow_o is set.
  - In both cases order_q advances by n, so the sink detects the gap through the order discontinuity.
- Pop: occurs when out_valid_o && out_ready_i at the posedge; the read pointer advances by 1.
- out_valid_o = (level != 0). Head fields are driven from registered storage and hold stable while out_valid_o && !out_ready_i.
- Latency: a record pushed at posedge N is visible on out_* after posedge N, when it is at the head.
- Simultaneous push and pop: level_next = level + pushed - popped. Both are legal when full (pop frees nothing for that cycle's admission decision).
- Pointers wrap modulo Depth; level distinguishes full from empty.
- flush_i=1: FIFO emptied and inputs that cycle discarded. Discarded inputs are not counted as drops and do not advance order. overflow_o, drop_cnt_o and order_q are unchanged.
- Priority: rst_i > flush_i > normal operation.

Test Plan:
- Reset, then lanes 0 and 1 both valid with pc 0x1000/0x1004, out_ready_i=1 -> records appear on consecutive cycles, pc 0x1000 order 0 then pc 0x1004 order 1, level_o peaks at 2.
- Only lane 1 valid with pc 0x2000 -> single record with order 0 from the lane-1 data; no bubble entry.
- out_ready_i=0, 2 records/cycle for 5 cycles with Depth=8 -> first 4 cycles accepted (level 8); 5th cycle dropped, drop_cnt_o=2, overflow_o=1. After releasing ready, orders read 0..7, and the next accepted record has order 10.
- level=7, two valid lanes, simultaneous pop -> both dropped (free=1 < 2), level_o=6 next cycle.
- Back-pressure: out_ready_i toggling 1/0 every cycle -> out_* stable while stalled; no record lost or duplicated across 20 pushes.
- flush_i with level=5 and two inputs asserted -> level_o=0 next cycle, drop_cnt_o unchanged, next accepted record order continues from the pre-flush order_q; rst_i mid-stream -> all outputs 0.
